// File: rtl/dm_block_mover_pkg.sv
// Shared op-codes and FSM state encodings for the block mover engine.
package dm_block_mover_pkg;

   localparam logic [1:0] DM_OP_FILL    = 2'b00;
   localparam logic [1:0] DM_OP_COPY    = 2'b01;
   localparam logic [1:0] DM_OP_COMPARE = 2'b10;
   localparam logic [1:0] DM_OP_RSVD    = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } dm_state_t;

   function automatic logic dm_op_is_reserved(input logic [1:0] op_code);
      return (op_code == DM_OP_RSVD);
   endfunction

endpackage

// File: rtl/dm_addr_gen.sv
// Loadable address pointer that steps up or down by one with natural wrap.
module dm_addr_gen #(
   parameter int ADDRESS_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_load,
   input  logic [ADDRESS_WIDTH-1:0] i_load_val,
   input  logic                     i_step,
   input  logic                     i_down,
   output logic [ADDRESS_WIDTH-1:0] o_ptr
);

   localparam logic [ADDRESS_WIDTH-1:0] LP_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

   logic [ADDRESS_WIDTH-1:0] r_ptr;

   // Pointer register: load has priority over stepping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_load) begin
         r_ptr <= i_load_val;
      end else if (i_step) begin
         r_ptr <= i_down ? (r_ptr - LP_ONE) : (r_ptr + LP_ONE);
      end else begin
         r_ptr <= r_ptr;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/dm_block_mover.sv
// Block FILL / COPY / COMPARE engine that owns the data_memory port while busy.
module dm_block_mover
   import dm_block_mover_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [1:0]               op,
   input  logic [ADDRESS_WIDTH-1:0] src_addr,
   input  logic [ADDRESS_WIDTH-1:0] dst_addr,
   input  logic [ADDRESS_WIDTH:0]   len,
   input  logic [DATA_WIDTH-1:0]    fill_value,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic                     mismatch,
   output logic [ADDRESS_WIDTH-1:0] mismatch_addr,
   output logic                     mem_wr,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata
);

   localparam logic [ADDRESS_WIDTH:0]   LP_CNT_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDRESS_WIDTH:0]   LP_CNT_ZERO = {(ADDRESS_WIDTH+1){1'b0}};
   localparam logic [ADDRESS_WIDTH-1:0] LP_A_ONE    = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

   dm_state_t                r_state;
   logic [1:0]               r_op;
   logic [DATA_WIDTH-1:0]    r_fill;
   logic [DATA_WIDTH-1:0]    r_capture;
   logic [ADDRESS_WIDTH:0]   r_cnt;
   logic                     r_down;
   logic                     r_err;
   logic                     r_mismatch;
   logic [ADDRESS_WIDTH-1:0] r_mm_addr;

   logic                     w_accept;
   logic                     w_desc;
   logic [ADDRESS_WIDTH-1:0] w_len_m1;
   logic [ADDRESS_WIDTH-1:0] w_src_load_val;
   logic [ADDRESS_WIDTH-1:0] w_dst_load_val;
   logic                     w_src_step;
   logic                     w_dst_step;
   logic                     w_match;
   logic [ADDRESS_WIDTH-1:0] w_src_ptr;
   logic [ADDRESS_WIDTH-1:0] w_dst_ptr;

   assign w_accept = (r_state == ST_IDLE) && start;
   // A forward-overlapping copy must start from the top so no word is read after being overwritten.
   assign w_desc   = (op == DM_OP_COPY) && (dst_addr > src_addr);
   // For len == 2**ADDRESS_WIDTH the low bits are zero, so this still yields the last offset.
   assign w_len_m1 = len[ADDRESS_WIDTH-1:0] - LP_A_ONE;
   assign w_src_load_val = w_desc ? (src_addr + w_len_m1) : src_addr;
   assign w_dst_load_val = w_desc ? (dst_addr + w_len_m1) : dst_addr;

   assign w_match    = (mem_rdata == r_fill);
   assign w_src_step = (r_state == ST_READ) || ((r_state == ST_CHECK) && w_match);
   assign w_dst_step = (r_state == ST_WRITE);

   dm_addr_gen #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_src_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_accept),
      .i_load_val (w_src_load_val),
      .i_step     (w_src_step),
      .i_down     (r_down),
      .o_ptr      (w_src_ptr)
   );

   dm_addr_gen #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_dst_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_accept),
      .i_load_val (w_dst_load_val),
      .i_step     (w_dst_step),
      .i_down     (r_down),
      .o_ptr      (w_dst_ptr)
   );

   // Command sequencer: one state per memory access, DONE pulses for a single cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_op       <= DM_OP_FILL;
         r_fill     <= '0;
         r_capture  <= '0;
         r_cnt      <= LP_CNT_ZERO;
         r_down     <= 1'b0;
         r_err      <= 1'b0;
         r_mismatch <= 1'b0;
         r_mm_addr  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_op       <= op;
                  r_fill     <= fill_value;
                  r_cnt      <= len;
                  r_down     <= w_desc;
                  r_err      <= 1'b0;
                  r_mismatch <= 1'b0;
                  r_mm_addr  <= '0;
                  if (dm_op_is_reserved(op)) begin
                     r_err   <= 1'b1;
                     r_state <= ST_DONE;
                  end else if (len == LP_CNT_ZERO) begin
                     r_state <= ST_DONE;
                  end else begin
                     case (op)
                        DM_OP_FILL: r_state <= ST_WRITE;
                        DM_OP_COPY: r_state <= ST_READ;
                        default:    r_state <= ST_CHECK;
                     endcase
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_READ: begin
               r_capture <= mem_rdata;
               r_state   <= ST_WRITE;
            end
            ST_WRITE: begin
               if (r_cnt == LP_CNT_ONE) begin
                  r_state <= ST_DONE;
               end else begin
                  r_cnt   <= r_cnt - LP_CNT_ONE;
                  r_state <= (r_op == DM_OP_COPY) ? ST_READ : ST_WRITE;
               end
            end
            ST_CHECK: begin
               if (!w_match) begin
                  r_mismatch <= 1'b1;
                  r_mm_addr  <= w_src_ptr;
                  r_state    <= ST_DONE;
               end else if (r_cnt == LP_CNT_ONE) begin
                  r_state <= ST_DONE;
               end else begin
                  r_cnt   <= r_cnt - LP_CNT_ONE;
                  r_state <= ST_CHECK;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Memory port is decoded from state only, so reset removes the write strobe immediately.
   assign mem_wr    = (r_state == ST_WRITE);
   assign mem_addr  = ((r_state == ST_READ) || (r_state == ST_CHECK)) ? w_src_ptr :
                      ((r_state == ST_WRITE) ? w_dst_ptr : '0);
   assign mem_wdata = (r_state == ST_WRITE) ?
                      ((r_op == DM_OP_COPY) ? r_capture : r_fill) : '0;

   assign busy          = (r_state != ST_IDLE);
   assign done          = (r_state == ST_DONE);
   assign err           = r_err;
   assign mismatch      = r_mismatch;
   assign mismatch_addr = r_mm_addr;

endmodule

// File: tb/tb_dm_block_mover.sv
// Directed scoreboard bench for dm_block_mover with a 16 x 1-bit memory model.
module tb_dm_block_mover;

   typedef struct {
      int          lat;
      logic        err;
      logic        mm;
      logic [3:0]  mm_addr;
      int          wrs;
      logic [15:0] mem;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [3:0]  src_addr;
   logic [3:0]  dst_addr;
   logic [4:0]  len;
   logic [0:0]  fill_value;
   logic        busy;
   logic        done;
   logic        err;
   logic        mismatch;
   logic [3:0]  mismatch_addr;
   logic        mem_wr;
   logic [3:0]  mem_addr;
   logic [0:0]  mem_wdata;
   logic [0:0]  mem_rdata;

   logic [15:0] mem;
   logic [15:0] ref_mem;
   logic        pre_en;
   logic [15:0] pre_val;
   exp_t        q[$];
   int          n_pass;
   int          n_total;

   dm_block_mover #(.ADDRESS_WIDTH(4), .DATA_WIDTH(1)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .op            (op),
      .src_addr      (src_addr),
      .dst_addr      (dst_addr),
      .len           (len),
      .fill_value    (fill_value),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .mismatch      (mismatch),
      .mismatch_addr (mismatch_addr),
      .mem_wr        (mem_wr),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_en) mem <= pre_val;
      else if (mem_wr) mem[mem_addr] <= mem_wdata[0];
   end
   assign mem_rdata = mem[mem_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic preload(input logic [15:0] v);
      @(negedge clk);
      pre_val = v;
      pre_en  = 1'b1;
      @(negedge clk);
      pre_en  = 1'b0;
      ref_mem = v;
   endtask

   task automatic run_cmd(input string tag, input logic [1:0] c_op, input int c_src,
                          input int c_dst, input int c_len, input logic c_val, input bit poke);
      exp_t        e;
      exp_t        g;
      logic [15:0] snap;
      int          k;
      int          w;
      int          n;
      bit          got;
      snap = ref_mem;
      e.mem = ref_mem; e.err = 1'b0; e.mm = 1'b0; e.mm_addr = 4'd0; e.wrs = 0; e.lat = 1;
      case (c_op)
         2'b00: begin
            for (int i = 0; i < c_len; i++) e.mem[(c_dst + i) & 15] = c_val;
            e.wrs = c_len; e.lat = c_len + 1;
         end
         2'b01: begin
            for (int i = 0; i < c_len; i++) e.mem[(c_dst + i) & 15] = snap[(c_src + i) & 15];
            e.wrs = c_len; e.lat = 2 * c_len + 1;
         end
         2'b10: begin
            n = c_len;
            for (int i = 0; i < c_len; i++) begin
               if (!e.mm && (snap[(c_src + i) & 15] !== c_val)) begin
                  e.mm = 1'b1; e.mm_addr = 4'((c_src + i) & 15); n = i + 1;
               end
            end
            e.lat = n + 1;
         end
         default: begin
            e.err = 1'b1; e.lat = 1;
         end
      endcase
      if (c_len == 0) e.lat = 1;
      ref_mem = e.mem;
      q.push_back(e);

      @(negedge clk);
      op = c_op; src_addr = c_src[3:0]; dst_addr = c_dst[3:0];
      len = c_len[4:0]; fill_value = c_val; start = 1'b1;
      k = 0; w = 0; got = 1'b0;
      while (k < 200 && !got) begin
         @(negedge clk);
         k++;
         if (k == 1) start = 1'b0;
         if (poke && k == 2) begin
            start = 1'b1; op = 2'b00; dst_addr = dst_addr + 4'd5;
            fill_value = ~c_val; len = 5'd3;
         end
         if (done) got = 1'b1;
         else if (mem_wr) w++;
      end
      start = 1'b0;
      check({tag, "/timeout"}, 32'(got), 32'd1);
      g = q.pop_front();
      check({tag, "/latency"}, 32'(k), 32'(g.lat));
      check({tag, "/busy_at_done"}, 32'(busy), 32'd1);
      check({tag, "/err"}, 32'(err), 32'(g.err));
      check({tag, "/mismatch"}, 32'(mismatch), 32'(g.mm));
      check({tag, "/mismatch_addr"}, 32'(mismatch_addr), 32'(g.mm_addr));
      check({tag, "/wr_cycles"}, 32'(w), 32'(g.wrs));
      @(negedge clk);
      check({tag, "/busy_after"}, 32'(busy), 32'd0);
      check({tag, "/err_held"}, 32'(err), 32'(g.err));
      check({tag, "/mem"}, 32'(mem), 32'(g.mem));
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst_n = 1'b0; start = 1'b0; op = 2'b00; src_addr = 4'd0; dst_addr = 4'd0;
      len = 5'd0; fill_value = 1'b0; pre_en = 1'b0; pre_val = 16'h0000; ref_mem = 16'h0000;
      #12;
      check("rst/busy", 32'(busy), 32'd0);
      check("rst/done", 32'(done), 32'd0);
      check("rst/err", 32'(err), 32'd0);
      check("rst/mismatch", 32'(mismatch), 32'd0);
      check("rst/mem_wr", 32'(mem_wr), 32'd0);
      check("rst/mem_addr", 32'(mem_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      preload(16'h0000);
      run_cmd("fill_3_4", 2'b00, 3, 3, 4, 1'b1, 1'b0);
      preload(16'h0000);
      run_cmd("fill_wrap", 2'b00, 0, 14, 4, 1'b1, 1'b0);
      preload(16'h0000);
      run_cmd("fill_all_poke", 2'b00, 0, 0, 16, 1'b1, 1'b1);
      preload(16'h000D);
      run_cmd("copy_fwd_overlap", 2'b01, 0, 2, 4, 1'b0, 1'b1);
      preload(16'h0034);
      run_cmd("copy_rev_overlap", 2'b01, 2, 0, 4, 1'b0, 1'b0);
      preload(16'h0020);
      run_cmd("cmp_mismatch", 2'b10, 0, 0, 8, 1'b0, 1'b0);
      preload(16'h0000);
      run_cmd("cmp_clean", 2'b10, 0, 0, 8, 1'b0, 1'b0);
      preload(16'hC003);
      run_cmd("cmp_wrap", 2'b10, 14, 0, 4, 1'b1, 1'b0);
      run_cmd("rsvd_op", 2'b11, 0, 0, 4, 1'b1, 1'b0);
      run_cmd("len_zero", 2'b00, 0, 5, 0, 1'b1, 1'b0);

      preload(16'h0000);
      @(negedge clk);
      op = 2'b00; dst_addr = 4'd0; len = 5'd8; fill_value = 1'b1; start = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      check("midrst/wr_before", 32'(mem_wr), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst/mem_wr", 32'(mem_wr), 32'd0);
      check("midrst/busy", 32'(busy), 32'd0);
      check("midrst/done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst/mem", 32'(mem), 32'h0007);
      ref_mem = 16'h0007;
      run_cmd("fill_after_rst", 2'b00, 0, 8, 2, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
